serial_addsub: RTL

Parametrised bit-serial adder/subtractor that processes one bit per clock, LSB first, through a single full-adder cell with a registered carry. It is the sequential successor to the team's combinational half/full adder cells. It trades WIDTH cycles of latency for one full-adder's worth of logic. It sits behind a start/busy/done handshake so a controller can issue back-to-back operations.

---
 rtl/serial_addsub_pkg.sv | 14 +
 rtl/serial_addsub_fa_cell.sv | 17 +
 rtl/serial_addsub.sv | 136 +++++++++++++
 3 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
// state_t  : controller state (IDLE, RUN), 1-bit encoding.
// ST_IDLE / ST_RUN : plain constants matching the enum for tools without enum support.
package serial_addsub_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_RUN  = 1'b1;

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// Combinational one-bit full adder, reusable by serial arithmetic blocks.
// i_x, i_y : operand bits
// i_ci     : carry in
// o_s      : sum bit
// o_co     : carry out (majority of the three inputs)
module fa_cell (
   input  logic i_x,
   input  logic i_y,
   input  logic i_ci,
   output logic o_s,
   output logic o_co
);

   assign o_s  = i_x ^ i_y ^ i_ci;
   assign o_co = (i_x & i_y) | (i_x & i_ci) | (i_y & i_ci);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, through a single
// full-adder cell with a registered carry. start/busy/done handshake.
// i_clk   : clock, rising edge
// i_rst   : asynchronous active-high reset
// i_start : request, sampled only while idle
// i_sub   : 0 = a+b, 1 = a-b (sampled with start)
// i_a/i_b : operands (sampled with start)
// o_busy  : operation in progress
// o_done  : one-cycle pulse when o_sum/o_cout/o_ovf update
// o_sum   : result, held until the next completion
// o_cout  : carry out of MSB (subtract: 1 = no borrow)
// o_ovf   : signed overflow
//
// state | meaning
// IDLE  | waiting for start; results held
// RUN   | shifting one bit per clock through the full adder
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_sub,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout,
   output logic             o_ovf
);

   localparam int                 CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic               w_load;
   logic               w_step;
   logic               w_finish;

   // r_a doubles as the result shift register: each sum bit enters at the MSB
   // as the consumed operand bit leaves at the LSB, so after WIDTH steps it
   // holds the completed result.
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic               r_carry;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_sum;
   logic               r_cout;
   logic               r_ovf;
   logic               r_done;
   logic               w_s;
   logic               w_c;

   fa_cell u_fa (
      .i_x  (r_a[0]),
      .i_y  (r_b[0]),
      .i_ci (r_carry),
      .o_s  (w_s),
      .o_co (w_c)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_load      = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            w_step = 1'b1;
            if (r_cnt == CNT_LAST) begin
               w_finish    = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= w_finish;
         if (w_load) begin
            // Subtraction: a + ~b + 1, the +1 coming in as the initial carry.
            r_a     <= i_a;
            r_b     <= i_sub ? ~i_b : i_b;
            r_carry <= i_sub;
            r_cnt   <= '0;
         end else if (w_step) begin
            r_a     <= {w_s, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_carry <= w_c;
            r_cnt   <= r_cnt + 1'b1;
         end
         if (w_finish) begin
            // On the last step r_carry is the carry into the MSB.
            r_sum  <= {w_s, r_a[WIDTH-1:1]};
            r_cout <= w_c;
            r_ovf  <= r_carry ^ w_c;
         end
      end
   end

   assign o_busy = (r_state == RUN);
   assign o_done = r_done;
   assign o_sum  = r_sum;
   assign o_cout = r_cout;
   assign o_ovf  = r_ovf;

endmodule
